led_vu_meter: RTL and testbench

- Parametrised LED level-meter driver; successor to the fixed 8-LED volume-threshold bar.
- Consumes codec output samples (left/right) on each valid strobe and tracks a decaying envelope. Drives an N-LED thermometer bar with a peak-hold dot.
- Sits beside the digital core at the top level; its LED output drives the board LEDs directly.

---
 rtl/led_vu_meter_if.sv | 12 +
 rtl/led_vu_meter.sv | 154 +++++++++++++++
 tb/tb_led_vu_meter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_vu_meter_if.sv
// Codec sample stream feeding the LED level meter: one strobe plus the
// signed left/right samples that are captured on its rising edge.
interface led_vu_meter_if #(
  parameter int DATA_W = 16
);
  logic                     valid;
  logic signed [DATA_W-1:0] lft_smp;
  logic signed [DATA_W-1:0] rht_smp;

  modport master (output valid, lft_smp, rht_smp);
  modport slave  (input  valid, lft_smp, rht_smp);
endinterface

// File: rtl/led_vu_meter.sv
// led_vu_meter: decaying-envelope LED bar with a peak-hold dot.
// A sample is accepted on each rising edge of the codec strobe. The envelope
// has instant attack and a shift-based release. The bar is a thermometer of
// envelope thresholds. A dot marks the held peak while the bar lies below it.
// Optional build macro VU_IDLE_BLANK_EN: blank the display after TIMEOUT_CYC
// idle clocks without an accepted sample.
module led_vu_meter #(
  parameter int NUM_LED     = 8,
  parameter int DATA_W      = 16,
  parameter int NOISE_FLOOR = 64,
  parameter int DECAY_SHIFT = 4,
  parameter int HOLD_SMP    = 24000,
  parameter int DROP_SMP    = 1200,
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic               clk,
  input  logic               rst_n,
  led_vu_meter_if.slave      smp,
  output logic [NUM_LED-1:0] LED
);

  localparam int MAG_W    = DATA_W - 1;
  localparam int FULL     = 2 ** (DATA_W - 1);
  localparam int STEP     = (FULL - NOISE_FLOOR) / NUM_LED;
  localparam int LVL_W    = $clog2(NUM_LED + 1);
  localparam int HOLD_MAX = (HOLD_SMP > DROP_SMP) ? HOLD_SMP : DROP_SMP;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam int STAGES   = 0;

  if (NUM_LED < 2 || NUM_LED > 16 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("led_vu_meter: parameter out of range");
  end

  logic               valid_q;
  logic               acc;
  logic [STAGES:0]    vld_pipe;  // acc delayed to the peak/LED stage
  logic [MAG_W-1:0]   env;
  logic [MAG_W-1:0]   mag;
  logic [MAG_W-1:0]   mag_l;
  logic [MAG_W-1:0]   mag_r;
  logic [MAG_W-1:0]   dec;
  logic [NUM_LED-1:0] bar;
  logic [NUM_LED-1:0] dot;
  logic [LVL_W-1:0]   level;
  logic [LVL_W-1:0]   peak;
  logic [LVL_W-1:0]   peak_nxt;
  logic [HOLD_W-1:0]  hold;
  logic [HOLD_W-1:0]  hold_nxt;
  logic               blank;

  // Saturating absolute value: the most-negative code clips to full scale.
  function automatic logic [MAG_W-1:0] abs_sat(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] neg;
    neg = ~x + DATA_W'(1);
    if (!x[DATA_W-1])          return x[MAG_W-1:0];
    else if (neg[DATA_W-1])    return '1;
    else                       return neg[MAG_W-1:0];
  endfunction

  assign acc   = smp.valid & ~valid_q;
  assign mag_l = abs_sat(smp.lft_smp);
  assign mag_r = abs_sat(smp.rht_smp);
  assign mag   = (mag_l > mag_r) ? mag_l : mag_r;

  // Release step: at least 1 while env is nonzero so small envelopes reach 0.
  always_comb begin
    dec = env >> DECAY_SHIFT;
    if (dec == '0 && env != '0) dec = MAG_W'(1);
  end

`ifdef VU_IDLE_BLANK_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle;

  // Idle clocks since the last accepted sample, saturating at the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               idle <= '0;
    else if (acc)                             idle <= '0;
    else if (idle != IDLE_W'(TIMEOUT_CYC))    idle <= idle + 1'b1;
  end

  assign blank = (idle == IDLE_W'(TIMEOUT_CYC));
`else
  assign blank = 1'b0;
`endif

  // Strobe edge detect, acc pipeline and envelope tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      vld_pipe <= '0;
      env      <= '0;
    end else begin
      valid_q  <= smp.valid;
      vld_pipe <= acc;
      if (acc)        env <= (mag >= env) ? mag : env - dec;
      else if (blank) env <= '0;
    end
  end

  // Bar thresholds: LED i lights once env reaches NOISE_FLOOR + i*STEP.
  for (genvar i = 0; i < NUM_LED; i++) begin : g_bar
    localparam int THR = NOISE_FLOOR + i * STEP;
    assign bar[i] = (32'(env) >= 32'(THR));
  end

  // Level is the number of lit bar segments.
  always_comb begin
    level = '0;
    for (int i = 0; i < NUM_LED; i++) level = level + LVL_W'(bar[i]);
  end

  // Peak hold/drop, advanced only in the cycle after an accepted sample.
  always_comb begin
    peak_nxt = peak;
    hold_nxt = hold;
    if (vld_pipe[0]) begin
      if (level >= peak) begin
        peak_nxt = level;
        hold_nxt = HOLD_W'(HOLD_SMP);
      end else if (hold != '0) begin
        hold_nxt = hold - 1'b1;
      end else begin
        peak_nxt = peak - 1'b1;
        hold_nxt = HOLD_W'(DROP_SMP);
      end
    end
  end

  // Peak dot sits above the bar only.
  always_comb begin
    dot = '0;
    for (int i = 0; i < NUM_LED; i++)
      dot[i] = (peak_nxt > level) && (peak_nxt == LVL_W'(i + 1));
  end

  // Peak state and registered LED drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak <= '0;
      hold <= '0;
      LED  <= '0;
    end else if (blank) begin
      peak <= '0;
      hold <= '0;
      LED  <= '0;
    end else begin
      peak <= peak_nxt;
      hold <= hold_nxt;
      LED  <= bar | dot;
    end
  end

endmodule

// File: tb/tb_led_vu_meter.sv
// Self-checking bench for led_vu_meter with a behavioural level/peak model.
module tb_led_vu_meter;
  localparam int NUM_LED = 8;
  localparam int DATA_W  = 16;
  localparam int NF      = 64;
  localparam int DS      = 4;
  localparam int HOLD    = 4;
  localparam int DROP    = 2;
  localparam int TMO     = 100;
  localparam int FULL    = 1 << (DATA_W - 1);
  localparam int STEP    = (FULL - NF) / NUM_LED;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_LED-1:0] led;

  led_vu_meter_if #(.DATA_W(DATA_W)) smp ();

  led_vu_meter #(
    .NUM_LED(NUM_LED), .DATA_W(DATA_W), .NOISE_FLOOR(NF), .DECAY_SHIFT(DS),
    .HOLD_SMP(HOLD), .DROP_SMP(DROP), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .smp(smp), .LED(led)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_env = 0, m_peak = 0, m_hold = 0;

  function automatic int mag_of(input int x);
    int a;
    a = (x < 0) ? -x : x;
    return (a > FULL - 1) ? FULL - 1 : a;
  endfunction

  function automatic int level_of(input int e);
    int l;
    if (e < NF) return 0;
    l = (e - NF) / STEP + 1;
    return (l > NUM_LED) ? NUM_LED : l;
  endfunction

  function automatic logic [NUM_LED-1:0] model_led();
    int lv, v;
    lv = level_of(m_env);
    v = (1 << lv) - 1;
    if (m_peak > lv && m_peak > 0) v = v | (1 << (m_peak - 1));
    return v[NUM_LED-1:0];
  endfunction

  task automatic model_sample(input int l, input int r);
    int m, d, lv;
    m = (mag_of(l) > mag_of(r)) ? mag_of(l) : mag_of(r);
    if (m >= m_env) m_env = m;
    else begin
      d = m_env / (1 << DS);
      if (d == 0 && m_env > 0) d = 1;
      m_env = (m_env - d < 0) ? 0 : m_env - d;
    end
    lv = level_of(m_env);
    if (lv >= m_peak) begin m_peak = lv; m_hold = HOLD; end
    else if (m_hold > 0) m_hold = m_hold - 1;
    else begin m_peak = m_peak - 1; m_hold = DROP; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    smp.valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_env = 0; m_peak = 0; m_hold = 0;
  endtask

  // One valid pulse of 'width' cycles (min 2); LED sampled two edges after acc.
  task automatic drive(input int l, input int r, input int width,
                       output logic [NUM_LED-1:0] got);
    @(negedge clk);
    smp.lft_smp = DATA_W'(l);
    smp.rht_smp = DATA_W'(r);
    smp.valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    smp.lft_smp = DATA_W'($urandom);
    smp.rht_smp = DATA_W'($urandom);
    @(posedge clk);
    #1 got = led;
    if (width > 2) repeat (width - 2) @(posedge clk);
    @(negedge clk);
    smp.valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    smp.valid = 1'b0;
    smp.lft_smp = '0;
    smp.rht_smp = '0;
    #35;
    checks++;
    if (led !== '0) begin errors++; $display("FAIL reset_led got=%h exp=00", led); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 checks++;
    if (led !== '0) begin errors++; $display("FAIL post_reset_idle got=%h exp=00", led); end
  endtask

  task automatic test_single_pulse();
    logic [NUM_LED-1:0] got;
    // explicit latency: LED unchanged one edge after acc, updated at the second
    @(negedge clk);
    smp.lft_smp = 16'sd5000;
    smp.rht_smp = -16'sd100;
    smp.valid = 1'b1;
    @(posedge clk);
    #1 checks++;
    if (led !== 8'h00) begin errors++; $display("FAIL latency_t1 got=%h exp=00", led); end
    @(posedge clk);
    #1 checks++;
    model_sample(5000, -100);
    if (led !== 8'h03 || model_led() !== 8'h03) begin
      errors++; $display("FAIL single_5000 got=%h exp=03 model=%h", led, model_led());
    end
    @(negedge clk);
    smp.valid = 1'b0;
    // 20-cycle pulse of zeros: exactly one decay step
    drive(0, 0, 20, got);
    model_sample(0, 0);
    checks++;
    if (got !== model_led()) begin errors++; $display("FAIL wide_pulse_t2 got=%h exp=%h", got, model_led()); end
    @(posedge clk);
    #1 checks++;
    if (led !== model_led()) begin errors++; $display("FAIL wide_pulse_end got=%h exp=%h", led, model_led()); end
  endtask

  task automatic test_full_scale();
    logic [NUM_LED-1:0] got;
    do_reset();
    drive(-32768, 0, 2, got);
    model_sample(-32768, 0);
    checks++;
    if (got !== 8'hFF) begin errors++; $display("FAIL full_neg got=%h exp=FF", got); end
    drive(0, 0, 3, got);
    model_sample(0, 0);
    checks++;
    if (got !== 8'hFF || m_env != 30720) begin
      errors++; $display("FAIL full_decay1 got=%h exp=FF", got);
    end
    do_reset();
    drive(0, 32767, 2, got);
    model_sample(0, 32767);
    checks++;
    if (got !== 8'hFF) begin errors++; $display("FAIL full_pos got=%h exp=FF", got); end
    // exact threshold: env == 64 lights LED[0], 63 does not
    do_reset();
    drive(64, 0, 2, got);
    model_sample(64, 0);
    checks++;
    if (got !== 8'h01) begin errors++; $display("FAIL thr_eq got=%h exp=01", got); end
    do_reset();
    drive(-63, 0, 2, got);
    model_sample(-63, 0);
    checks++;
    if (got !== 8'h00) begin errors++; $display("FAIL thr_below got=%h exp=00", got); end
  endtask

  task automatic test_peak_hold();
    logic [NUM_LED-1:0] got;
    do_reset();
    drive(16000, 0, 2, got);
    model_sample(16000, 0);
    checks++;
    if (got !== 8'h0F) begin errors++; $display("FAIL peak_first got=%h exp=0F", got); end
    for (int k = 0; k < 30; k++) begin
      drive(0, 0, 2, got);
      model_sample(0, 0);
      checks++;
      if (got !== model_led()) begin
        errors++; $display("FAIL peak_zero[%0d] got=%h exp=%h", k, got, model_led());
      end
    end
  endtask

  task automatic test_decay_floor();
    logic [NUM_LED-1:0] got;
    do_reset();
    drive(20, 0, 2, got);
    model_sample(20, 0);
    for (int k = 0; k < 24; k++) begin
      drive(0, 0, 2, got);
      model_sample(0, 0);
      checks++;
      if (got !== model_led()) begin
        errors++; $display("FAIL decay_floor[%0d] got=%h exp=%h", k, got, model_led());
      end
    end
    // from 20, 24 unit steps must have bottomed out without wrapping to full scale
    drive(0, 0, 2, got);
    checks++;
    if (got !== 8'h00) begin errors++; $display("FAIL decay_underflow got=%h exp=00", got); end
  endtask

  task automatic test_async_reset();
    logic [NUM_LED-1:0] got;
    do_reset();
    drive(18000, 0, 2, got);
    model_sample(18000, 0);
    drive(0, 0, 2, got);
    model_sample(0, 0);
    checks++;
    if (got !== 8'h1F) begin errors++; $display("FAIL pre_reset got=%h exp=1F", got); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checks++;
    if (led !== 8'h00) begin errors++; $display("FAIL async_reset got=%h exp=00", led); end
    m_env = 0; m_peak = 0; m_hold = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 checks++;
    if (led !== 8'h00) begin errors++; $display("FAIL after_reset_idle got=%h exp=00", led); end
  endtask

  task automatic test_random();
    logic [NUM_LED-1:0] got;
    int l, r;
    for (int k = 0; k < 60; k++) begin
      l = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 65535)) - 32768;
      r = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 65535)) - 32768;
      drive(l, r, int'($urandom_range(2, 4)), got);
      model_sample(l, r);
      checks++;
      if (got !== model_led()) begin
        errors++; $display("FAIL random[%0d] l=%0d r=%0d got=%h exp=%h", k, l, r, got, model_led());
      end
    end
  endtask

  task automatic test_idle();
    logic [NUM_LED-1:0] got;
    logic [NUM_LED-1:0] exp_late;
    do_reset();
    drive(9000, 0, 2, got);
    model_sample(9000, 0);
    checks++;
    if (got !== 8'h07) begin errors++; $display("FAIL idle_start got=%h exp=07", got); end
    repeat (90) @(posedge clk);
    #1 checks++;
    if (led !== 8'h07) begin errors++; $display("FAIL idle_early got=%h exp=07", led); end
`ifdef VU_IDLE_BLANK_EN
    exp_late = '0;
`else
    exp_late = 8'h07;
`endif
    repeat (20) @(posedge clk);
    #1 checks++;
    if (led !== exp_late) begin errors++; $display("FAIL idle_late got=%h exp=%h", led, exp_late); end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_full_scale();
    test_peak_hold();
    test_decay_floor();
    test_async_reset();
    test_random();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
